// File: rtl/pc_gen_btb.sv
// Fetch-PC generator with a direct-mapped BTB: one aligned fetch address per
// cycle, execute-stage redirects, and taken-branch prediction trained from execute.
module pc_gen_btb #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                BTB_ENTRIES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  output logic              sending,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];

  logic              sending_q, sending_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              pred_taken_q, pred_taken_d;
  logic [ADDR_W-1:0] pred_target_q, pred_target_d;

  logic [ADDR_W-1:0] fetch_addr;
  logic [IDX_W-1:0]  lk_idx;
  logic              lk_hit;
  logic [ADDR_W-1:0] lk_next;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              unused_upd_lsb;

  assign upd_idx        = upd_pc[IDX_W+1:2];
  assign upd_tag        = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_upd_lsb = ^upd_pc[1:0];

  // Lookup stage: BTB read uses the contents before this edge's update
  always_comb begin
    fetch_addr = br ? align(br_addr) : pc_q;
    lk_idx     = fetch_addr[IDX_W+1:2];
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == fetch_addr[ADDR_W-1:IDX_W+2]);
    lk_next    = lk_hit ? tgt_q[lk_idx] : fetch_addr + ADDR_W'(4);
  end

  always_comb begin
    pc_d          = pc_q;
    sending_d     = sending_q;
    pc_out_d      = pc_out_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (br || !stall) begin
      pc_d          = lk_next;
      sending_d     = 1'b1;
      pc_out_d      = fetch_addr;
      pred_taken_d  = lk_hit;
      pred_target_d = lk_hit ? tgt_q[lk_idx] : '0;
    end
  end

  // Fetch output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      sending_q     <= 1'b0;
      pc_out_q      <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      sending_q     <= sending_d;
      pc_out_q      <= pc_out_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // BTB training: taken installs/replaces, not-taken invalidates only its own tag
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_taken)
        valid_q[upd_idx] <= 1'b1;
      else if (tag_q[upd_idx] == upd_tag)
        valid_q[upd_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && upd_valid && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= align(upd_target);
    end
  end

  assign sending     = sending_q;
  assign pc_o        = pc_out_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Scoreboard bench for pc_gen_btb: a behavioural fetch/BTB model queues the
// expected outputs per cycle and a monitor compares them after each edge.
module tb_pc_gen_btb;

  localparam int N = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        sending;
  logic [31:0] pc_o;
  logic        pred_taken;
  logic [31:0] pred_target;

  pc_gen_btb #(.ADDR_W(32), .RESET_PC(32'h0), .BTB_ENTRIES(N)) dut (
    .clock(clock), .reset(reset), .stall(stall), .br(br), .br_addr(br_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .sending(sending), .pc_o(pc_o),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        s;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc = 32'h0;
  logic        m_send = 1'b0;
  logic [31:0] m_pco = '0;
  logic        m_pt = 1'b0;
  logic [31:0] m_ptg = '0;
  logic        m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];

  task automatic step(input logic r, input logic st, input logic b, input logic [31:0] ba,
                      input logic uv, input logic [31:0] up, input logic [31:0] ut,
                      input logic utk);
    logic [31:0] a;
    logic        hit;
    int          i;
    @(negedge clock);
    reset = r; stall = st; br = b; br_addr = ba;
    upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = utk;
    if (r) begin
      m_pc = 32'h0; m_send = 1'b0; m_pco = '0; m_pt = 1'b0; m_ptg = '0;
      for (int j = 0; j < N; j++) m_v[j] = 1'b0;
    end else begin
      if (b || !st) begin
        a   = b ? (ba & ~32'h3) : m_pc;
        i   = int'((a / 4) % N);
        hit = m_v[i] && (m_tag[i] == a / (4 * N));
        m_pco  = a;
        m_send = 1'b1;
        m_pt   = hit;
        m_ptg  = hit ? m_tgt[i] : 32'h0;
        m_pc   = hit ? m_tgt[i] : a + 32'd4;
      end
      if (uv) begin
        i = int'((up / 4) % N);
        if (utk) begin
          m_v[i] = 1'b1; m_tag[i] = up / (4 * N); m_tgt[i] = ut & ~32'h3;
        end else if (m_v[i] && m_tag[i] == up / (4 * N)) begin
          m_v[i] = 1'b0;
        end
      end
    end
    exp_q.push_back('{s: m_send, pc: m_pco, pt: m_pt, tg: m_ptg});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input logic [31:0] a);
    step(0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] p, input logic [31:0] t, input logic tk);
    step(0, 1, 0, 0, 1, p, t, tk);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return $urandom & 32'h3FF;
  endfunction

  // Monitor: one expected entry per clock edge, compared after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sending !== e.s || pc_o !== e.pc || pred_taken !== e.pt || pred_target !== e.tg) begin
          errors++;
          $display("FAIL fetch t=%0t got s=%0b pc=%h pt=%0b tg=%h want s=%0b pc=%h pt=%0b tg=%h",
                   $time, sending, pc_o, pred_taken, pred_target, e.s, e.pc, e.pt, e.tg);
        end
      end
    end
  end

  initial begin
    for (int j = 0; j < N; j++) begin m_v[j] = 1'b0; m_tag[j] = '0; m_tgt[j] = '0; end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run(4);                                    // 0,4,8,C
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run(3);                                    // 0,4,8
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 0, 0);
    run(1);                                    // C
    step(0, 1, 1, 32'h103, 0, 0, 0, 0);        // 0x100 despite stall
    run(1);                                    // 0x104
    train(32'h10, 32'h40, 1);
    go(32'h10); run(2);                        // hit -> 0x40
    train(32'h10, 32'h0, 0);
    go(32'h10); run(1);                        // miss -> 0x14
    train(32'h10, 32'h40, 1);
    train(32'h50, 32'h80, 1);
    go(32'h10); run(1);                        // evicted: miss
    go(32'h50); run(1);                        // hit -> 0x80
    step(0, 0, 1, 32'h50, 1, 32'h50, 0, 0);    // same-cycle invalidate: old hit seen
    go(32'h50); run(1);                        // now a miss
    step(0, 0, 1, 32'h20, 1, 32'h20, 32'h200, 1); // same-cycle install: old miss seen
    go(32'h20); run(1);                        // hit -> 0x200
    go(32'hFFFF_FFFC); run(1);                 // wraps to 0
    step(1, 0, 1, 32'h300, 1, 32'h40, 32'h90, 1); // reset beats br and update
    run(1);
    go(32'h20); run(1);                        // BTB cleared
    go(32'h40); run(1);
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           rand_addr(), $urandom_range(0, 2) == 0, rand_addr(), rand_addr(),
           1'($urandom_range(0, 1)));
    step(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
